load_port_responder: RTL and testbench

LOAD_PORT_RESPONDER -- requirements
Module: load_port_responder

---
 rtl/load_port_responder.sv | 173 +++++++++++++++++
 tb/tb_load_port_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_port_responder.sv
// Fully-associative buffer of 64-bit words that answers a dcache-style load port.
// Load misses are fetched through a level-held fill request. Stores merge only into entries that hit.
module load_port_responder #(
  parameter int NUM_ENTRIES        = 4,
  parameter int DCACHE_INDEX_WIDTH = 12,
  parameter int DCACHE_TAG_WIDTH   = 44,
  localparam int REQ_WIDTH  = DCACHE_INDEX_WIDTH + DCACHE_TAG_WIDTH + 64 + 14,
  localparam int RESP_WIDTH = 66,
  localparam int ADDR_WIDTH = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic [REQ_WIDTH-1:0]  req_i,
  output logic [RESP_WIDTH-1:0] resp_o,
  output logic                  fill_req_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  input  logic                  fill_valid_i,
  input  logic [63:0]           fill_data_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int IW    = DCACHE_INDEX_WIDTH;
  localparam int TW    = DCACHE_TAG_WIDTH;
  localparam int KEY_W = ADDR_WIDTH - 3;
  localparam int PTR_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {IDLE, TAG, FILL} state_t;

  state_t state;

  logic [IW-1:0] address_index;
  logic [TW-1:0] address_tag;
  logic [63:0]   data_wdata;
  logic          data_req;
  logic          data_we;
  logic [7:0]    data_be;
  logic [1:0]    data_size;
  logic          kill_req;
  logic          tag_valid;

  logic        data_gnt;
  logic        data_rvalid;
  logic [63:0] data_rdata;

  logic [IW-1:0] cap_index;
  logic          cap_we;
  logic [63:0]   cap_wdata;
  logic [7:0]    cap_be;

  logic [NUM_ENTRIES-1:0] valid;
  logic [KEY_W-1:0]       entry_key  [NUM_ENTRIES];
  logic [63:0]            entry_data [NUM_ENTRIES];
  logic [PTR_W-1:0]       ptr;
  logic                   kill_seen;

  logic [KEY_W-1:0] lookup_key;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic [63:0]      hit_data;
  logic [63:0]      merged_data;
  logic             unused_bits;

  assign {address_index, address_tag, data_wdata, data_req, data_we,
          data_be, data_size, kill_req, tag_valid} = req_i;
  assign resp_o      = {data_gnt, data_rvalid, data_rdata};
  assign data_gnt    = (state == IDLE) && data_req;
  assign unused_bits = ^{data_size, cap_index[2:0]};

  // The tag arrives in the TAG cycle; the index was captured at grant time.
  assign lookup_key = {address_tag, cap_index[IW-1:3]};

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_data = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid[i] && (entry_key[i] == lookup_key)) begin
        hit      = 1'b1;
        hit_idx  = PTR_W'(i);
        hit_data = entry_data[i];
      end
    end
  end

  always_comb begin
    merged_data = hit_data;
    for (int b = 0; b < 8; b++) begin
      if (cap_be[b]) merged_data[8*b +: 8] = cap_wdata[8*b +: 8];
    end
  end

  // rvalid/rdata default low each cycle, so a response lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      valid       <= '0;
      ptr         <= '0;
      kill_seen   <= 1'b0;
      fill_req_o  <= 1'b0;
      fill_addr_o <= '0;
      data_rvalid <= 1'b0;
      data_rdata  <= '0;
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
      cap_index   <= '0;
      cap_we      <= 1'b0;
      cap_wdata   <= '0;
      cap_be      <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        entry_key[i]  <= '0;
        entry_data[i] <= '0;
      end
    end else begin
      data_rvalid <= 1'b0;
      data_rdata  <= '0;
      case (state)
        IDLE: begin
          if (data_gnt) begin
            cap_index <= address_index;
            cap_we    <= data_we;
            cap_wdata <= data_wdata;
            cap_be    <= data_be;
            state     <= TAG;
          end
        end
        TAG: begin
          if (tag_valid) begin
            if (kill_req) begin
              state <= IDLE;
            end else if (cap_we) begin
              if (hit) entry_data[hit_idx] <= merged_data;
              state <= IDLE;
            end else if (hit) begin
              data_rvalid <= 1'b1;
              data_rdata  <= hit_data;
              hit_cnt_o   <= sat_inc(hit_cnt_o);
              state       <= IDLE;
            end else begin
              miss_cnt_o  <= sat_inc(miss_cnt_o);
              fill_addr_o <= {lookup_key, 3'b000};
              fill_req_o  <= 1'b1;
              kill_seen   <= 1'b0;
              state       <= FILL;
            end
          end
        end
        FILL: begin
          if (kill_req) kill_seen <= 1'b1;
          // A killed fill still allocates; it only suppresses the response.
          if (fill_valid_i) begin
            entry_key[ptr]  <= fill_addr_o[ADDR_WIDTH-1:3];
            entry_data[ptr] <= fill_data_i;
            valid[ptr]      <= 1'b1;
            ptr             <= ptr + PTR_W'(1);
            fill_req_o      <= 1'b0;
            if (!(kill_seen || kill_req)) begin
              data_rvalid <= 1'b1;
              data_rdata  <= fill_data_i;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_port_responder.sv
// Directed and randomized bench for load_port_responder, checked against a FIFO-of-words cache model.
module tb_load_port_responder;

  localparam int N  = 4;
  localparam int KW = 53;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [11:0] index;
  logic [43:0] tag;
  logic [63:0] wdata;
  logic        data_req, data_we;
  logic [7:0]  be;
  logic [1:0]  size;
  logic        kill, tag_valid;

  logic [133:0] req_i;
  logic [65:0]  resp_o;
  logic         gnt, rvalid;
  logic [63:0]  rdata;
  logic         fill_req_o;
  logic [55:0]  fill_addr_o;
  logic         fill_valid_i;
  logic [63:0]  fill_data_i;
  logic [31:0]  hit_cnt_o, miss_cnt_o;

  assign req_i = {index, tag, wdata, data_req, data_we, be, size, kill, tag_valid};
  assign {gnt, rvalid, rdata} = resp_o;

  always #5 clk = ~clk;

  load_port_responder #(.NUM_ENTRIES(N)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .resp_o      (resp_o),
    .fill_req_o  (fill_req_o),
    .fill_addr_o (fill_addr_o),
    .fill_valid_i(fill_valid_i),
    .fill_data_i (fill_data_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: the buffer holds the last N allocated words, oldest first.
  logic [KW-1:0] m_addr[$];
  logic [63:0]   m_data[$];
  logic [31:0]   m_hits   = '0;
  logic [31:0]   m_misses = '0;

  task automatic check_output(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_find(input logic [KW-1:0] key);
    foreach (m_addr[i]) if (m_addr[i] == key) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // kill_mode: 0 none, 1 kill with the tag, 2 kill one cycle in FILL, 3 reset in FILL.
  task automatic apply_stimulus(input logic is_store, input logic [11:0] idx, input logic [43:0] tg,
                                input logic [63:0] wd, input logic [7:0] bmask, input int kill_mode,
                                input logic [63:0] fdata, input int stall);
    logic [KW-1:0] key;
    logic [63:0]   merged;
    int            pos;
    int            delay;
    logic          expect_rv;
    key = {tg, idx[11:3]};
    pos = model_find(key);

    data_req = 1'b1; data_we = is_store; index = idx; wdata = wd; be = bmask;
    tag_valid = 1'b0; kill = 1'b0; tag = 44'($urandom);
    fill_valid_i = 1'($urandom_range(0, 1)); fill_data_i = {$urandom, $urandom};
    #1 check_output("gnt_idle", gnt, 1'b1);
    tick();
    fill_valid_i = 1'b0;
    data_req = 1'b0; data_we = ~is_store; index = 12'($urandom);
    wdata = {$urandom, $urandom}; be = 8'($urandom);

    for (int s = 0; s < stall; s++) begin
      data_req = 1'($urandom_range(0, 1));
      kill = 1'($urandom_range(0, 1));
      #1 check_output("gnt_tag_stall", gnt, 1'b0);
      tick();
    end
    data_req = 1'b0;

    tag = tg; tag_valid = 1'b1; kill = (kill_mode == 1);
    #1 check_output("gnt_tag", gnt, 1'b0);
    tick();
    tag_valid = 1'b0; kill = 1'b0;

    if (kill_mode == 1) begin
      check_output("kill_tag_rvalid", rvalid, 1'b0);
      check_output("kill_tag_fill_req", fill_req_o, 1'b0);
    end else if (is_store) begin
      if (pos >= 0) begin
        merged = m_data[pos];
        for (int b = 0; b < 8; b++) if (bmask[b]) merged[8*b +: 8] = wd[8*b +: 8];
        m_data[pos] = merged;
      end
      check_output("store_rvalid", rvalid, 1'b0);
      check_output("store_rdata", rdata, 64'd0);
      check_output("store_fill_req", fill_req_o, 1'b0);
    end else if (pos >= 0) begin
      m_hits = model_inc(m_hits);
      check_output("hit_rvalid", rvalid, 1'b1);
      check_output("hit_rdata", rdata, m_data[pos]);
      check_output("hit_fill_req", fill_req_o, 1'b0);
    end else begin
      m_misses = model_inc(m_misses);
      check_output("miss_fill_req", fill_req_o, 1'b1);
      check_output("miss_fill_addr", fill_addr_o, {key, 3'b000});
      check_output("miss_rvalid", rvalid, 1'b0);
      check_output("miss_rdata", rdata, 64'd0);
      if (kill_mode == 3) begin
        rst_i = 1'b1;
        #1;
        m_addr = {}; m_data = {}; m_hits = '0; m_misses = '0;
        check_output("rst_fill_req", fill_req_o, 1'b0);
        check_output("rst_fill_addr", fill_addr_o, 56'd0);
        tick();
        rst_i = 1'b0;
        fill_valid_i = 1'b1; fill_data_i = fdata;
        tick();
        fill_valid_i = 1'b0;
        check_output("rst_late_fill_rvalid", rvalid, 1'b0);
        check_output("rst_late_fill_req", fill_req_o, 1'b0);
      end else begin
        delay = $urandom_range(1, 3);
        for (int k = 0; k < delay; k++) begin
          kill = (kill_mode == 2) && (k == 0);
          data_req = 1'($urandom_range(0, 1));
          #1;
          check_output("fill_req_held", fill_req_o, 1'b1);
          check_output("fill_addr_held", fill_addr_o, {key, 3'b000});
          check_output("gnt_fill", gnt, 1'b0);
          tick();
        end
        kill = 1'b0; data_req = 1'b0;
        fill_valid_i = 1'b1; fill_data_i = fdata;
        tick();
        fill_valid_i = 1'b0;
        expect_rv = (kill_mode != 2);
        check_output("fill_rvalid", rvalid, expect_rv);
        check_output("fill_rdata", rdata, expect_rv ? fdata : 64'd0);
        check_output("fill_req_drop", fill_req_o, 1'b0);
        m_addr.push_back(key);
        m_data.push_back(fdata);
        if (m_addr.size() > N) begin
          void'(m_addr.pop_front());
          void'(m_data.pop_front());
        end
      end
    end
    check_output("hit_cnt", hit_cnt_o, m_hits);
    check_output("miss_cnt", miss_cnt_o, m_misses);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [43:0] tg;
    logic [11:0] idx;
    logic        st;
    int          r;
    int          km;

    rst_i = 1'b1; data_req = 1'b1; data_we = 1'b0; index = '0; tag = '0; wdata = '0;
    be = '0; size = 2'b11; kill = 1'b0; tag_valid = 1'b0; fill_valid_i = 1'b0; fill_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_gnt", gnt, 1'b1);
    check_output("reset_rvalid", rvalid, 1'b0);
    check_output("reset_rdata", rdata, 64'd0);
    check_output("reset_fill_req", fill_req_o, 1'b0);
    check_output("reset_fill_addr", fill_addr_o, 56'd0);
    check_output("reset_hit_cnt", hit_cnt_o, 32'd0);
    check_output("reset_miss_cnt", miss_cnt_o, 32'd0);
    data_req = 1'b0;
    rst_i = 1'b0;
    tick();

    $display("[TB] miss then hit");
    apply_stimulus(1'b0, 12'h040, 44'h0AB_CDEF_0123, '0, '0, 0, 64'hDEAD_BEEF_0000_0001, 0);
    apply_stimulus(1'b0, 12'h040, 44'h0AB_CDEF_0123, '0, '0, 0, '0, 0);

    $display("[TB] kill during fill");
    apply_stimulus(1'b0, 12'h088, 44'h000_0000_0B0B, '0, '0, 2, 64'h0123_4567_89AB_CDEF, 0);
    apply_stimulus(1'b0, 12'h08C, 44'h000_0000_0B0B, '0, '0, 0, '0, 1);

    $display("[TB] store merge");
    apply_stimulus(1'b0, 12'h100, 44'h000_0000_0C0C, '0, '0, 0, 64'h1111_1111_1111_1111, 0);
    apply_stimulus(1'b1, 12'h100, 44'h000_0000_0C0C, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0, '0, 0);
    apply_stimulus(1'b0, 12'h100, 44'h000_0000_0C0C, '0, '0, 0, '0, 0);

    $display("[TB] store miss and tag kill do not allocate");
    apply_stimulus(1'b1, 12'h200, 44'h000_0000_0D0D, 64'h5555_5555_5555_5555, 8'hFF, 0, '0, 0);
    apply_stimulus(1'b0, 12'h200, 44'h000_0000_0D0D, '0, '0, 0, 64'hAAAA_0000_AAAA_0000, 0);
    apply_stimulus(1'b0, 12'h300, 44'h000_0000_0E0E, '0, '0, 1, '0, 0);
    apply_stimulus(1'b0, 12'h300, 44'h000_0000_0E0E, '0, '0, 0, 64'h0E0E_0E0E_0E0E_0E0E, 0);

    $display("[TB] tag stall and reset in fill");
    apply_stimulus(1'b0, 12'h040, 44'h0AB_CDEF_0123, '0, '0, 0, '0, 5);
    apply_stimulus(1'b0, 12'h400, 44'h000_0000_0F0F, '0, '0, 3, 64'hBAD0_BAD0_BAD0_BAD0, 0);
    apply_stimulus(1'b0, 12'h040, 44'h0AB_CDEF_0123, '0, '0, 0, 64'h0000_0000_0000_0040, 0);

    $display("[TB] replacement wrap");
    for (int w = 0; w <= N; w++)
      apply_stimulus(1'b0, 12'h800, 44'(32'h7000_0000 + w), '0, '0, 0, {$urandom, $urandom}, 0);
    apply_stimulus(1'b0, 12'h800, 44'(32'h7000_0001), '0, '0, 0, '0, 0);
    apply_stimulus(1'b0, 12'h800, 44'(32'h7000_0000), '0, '0, 0, {$urandom, $urandom}, 0);

    $display("[TB] random traffic");
    for (int t = 0; t < 60; t++) begin
      tg  = 44'(32'hC0DE_0000 + $urandom_range(0, 2));
      idx = {9'($urandom_range(8, 10)), 3'($urandom)};
      st  = ($urandom_range(0, 3) == 0);
      r   = $urandom_range(0, 9);
      km  = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      apply_stimulus(st, idx, tg, {$urandom, $urandom}, 8'($urandom), km,
                     {$urandom, $urandom}, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
